// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a 5-stage in-order pipeline.
// Tracks in-flight register writes in a per-register scoreboard, detects RAW
// hazards in ID, and arbitrates between EX multi-cycle stalls and RAW stalls.
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall/RAW perf counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [3:0]  id_raddr1,
  input  logic [3:0]  id_raddr2,
  input  logic        id_wreg,
  input  logic [3:0]  id_wd,
  input  logic        ex_stallreq,
  input  logic        wb_wreg,
  input  logic [3:0]  wb_wd,
  output logic [5:0]  stall,
  output logic        id_bubble,
  output logic        ex_bubble,
  output logic [1:0]  ctrl_state,
  output logic        sb_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_raw_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_RAW = 2'd1,
    ST_EXW = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_cnt [16];
  logic       r_err;
  logic [1:0] w_eff [16];
  logic       w_raw;
  logic       w_issue;
  logic       w_retire;

  assign ctrl_state = r_state;
  assign sb_err     = r_err;

  // Effective in-flight count: a write retiring this cycle is already visible
  // through the register file bypass, so it no longer counts as a hazard.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_eff[i] = r_cnt[i];
      if (wb_wreg && (wb_wd == 4'(i)) && (r_cnt[i] != 2'd0))
        w_eff[i] = r_cnt[i] - 2'd1;
    end
  end

  // RAW hazard on either enabled source operand of a valid ID instruction.
  always_comb begin
    w_raw = id_valid & ((id_re1 & (w_eff[id_raddr1] != 2'd0)) |
                        (id_re2 & (w_eff[id_raddr2] != 2'd0)));
  end

  // Same-cycle stall/bubble outputs; EX stall beats RAW, and reset silences all.
  always_comb begin
    stall     = 6'b000000;
    id_bubble = 1'b0;
    ex_bubble = 1'b0;
    if (!rst) begin
      if (ex_stallreq) begin
        stall     = 6'b000111;
        ex_bubble = 1'b1;
      end else if (w_raw) begin
        stall     = 6'b000011;
        id_bubble = 1'b1;
      end
    end
  end

  assign w_issue  = id_valid & id_wreg & ~stall[1] & ~id_bubble;
  assign w_retire = wb_wreg;

  // Scoreboard counters with saturation/underflow protection and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_cnt[i] <= 2'd0;
      r_err <= 1'b0;
    end else if (!(w_issue && w_retire && (id_wd == wb_wd))) begin
      if (w_issue) begin
        if (r_cnt[id_wd] == 2'd3) r_err <= 1'b1;
        else                      r_cnt[id_wd] <= r_cnt[id_wd] + 2'd1;
      end
      if (w_retire) begin
        if (r_cnt[wb_wd] == 2'd0) r_err <= 1'b1;
        else                      r_cnt[wb_wd] <= r_cnt[wb_wd] - 2'd1;
      end
    end
  end

  // Control FSM: next state follows the current stall cause; unused code recovers to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_RAW, ST_EXW: begin
          if (ex_stallreq) r_state <= ST_EXW;
          else if (w_raw)  r_state <= ST_RAW;
          else             r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_raw;

  assign perf_stall_cnt = r_perf_stall;
  assign perf_raw_cnt   = r_perf_raw;

  // Saturating counters of stalled cycles and of cycles where a RAW stall is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 16'd0;
      r_perf_raw   <= 16'd0;
    end else begin
      if ((stall != 6'd0) && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
      if (id_bubble && (r_perf_raw != 16'hFFFF))
        r_perf_raw <= r_perf_raw + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor pops and compares on
// the falling edge of every cycle that has an expectation queued.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid, id_re1, id_re2, id_wreg;
  logic [3:0]  id_raddr1, id_raddr2, id_wd;
  logic        ex_stallreq, wb_wreg;
  logic [3:0]  wb_wd;
  logic [5:0]  stall;
  logic        id_bubble, ex_bubble, sb_err;
  logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt, perf_raw_cnt;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_re1(id_re1), .id_re2(id_re2),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_wreg(id_wreg), .id_wd(id_wd),
    .ex_stallreq(ex_stallreq), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
    .stall(stall), .id_bubble(id_bubble), .ex_bubble(ex_bubble),
    .ctrl_state(ctrl_state), .sb_err(sb_err)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_raw_cnt(perf_raw_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        idb;
    logic        exb;
    logic [1:0]  st;
    logic        err;
    logic        chkp;
    logic [15:0] ps;
    logic [15:0] pr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic        nxt_chkp = 1'b0;
  logic [15:0] nxt_ps = 16'd0;
  logic [15:0] nxt_pr = 16'd0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every queued expectation mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "stall",      16'(stall),      16'(e.stall));
      chk(e.name, "id_bubble",  16'(id_bubble),  16'(e.idb));
      chk(e.name, "ex_bubble",  16'(ex_bubble),  16'(e.exb));
      chk(e.name, "ctrl_state", 16'(ctrl_state), 16'(e.st));
      chk(e.name, "sb_err",     16'(sb_err),     16'(e.err));
`ifdef PIPE_CTRL_PERF_EN
      if (e.chkp) begin
        chk(e.name, "perf_stall", perf_stall_cnt, e.ps);
        chk(e.name, "perf_raw",   perf_raw_cnt,   e.pr);
      end
`endif
    end
  end

  task automatic cyc(input string nm, input logic r, input logic v,
                     input logic re1, input logic [3:0] a1,
                     input logic re2, input logic [3:0] a2,
                     input logic wr, input logic [3:0] wd,
                     input logic exs, input logic wbw, input logic [3:0] wbd,
                     input logic [5:0] es, input logic eib, input logic eeb,
                     input logic [1:0] est, input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_re1 = re1; id_raddr1 = a1; id_re2 = re2; id_raddr2 = a2;
    id_wreg = wr; id_wd = wd; ex_stallreq = exs; wb_wreg = wbw; wb_wd = wbd;
    e.name = nm; e.stall = es; e.idb = eib; e.exb = eeb; e.st = est; e.err = eerr;
    e.chkp = nxt_chkp; e.ps = nxt_ps; e.pr = nxt_pr;
    nxt_chkp = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_valid = 0; id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
    id_wreg = 0; id_wd = 0; ex_stallreq = 0; wb_wreg = 0; wb_wd = 0;
    //   name      rst v re1 a1 re2 a2 wr wd exs wbw wbd  stall   idb exb st err
    // Reset held two cycles while an instruction tries to issue r2
    cyc("rst0",     1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("rst1",     1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("rst_rd2",  0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    // RAW on r2, cleared by a same-cycle writeback
    cyc("raw_iss",  0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("raw_c1",   0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd3, 1, 0, 0, 0);
    cyc("raw_c2",   0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd3, 1, 0, 1, 0);
    cyc("raw_wb",   0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 2, 6'd0, 0, 0, 1, 0);
    cyc("raw_done", 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    // EX stall outranks RAW; blocked issues must not bump the scoreboard
    cyc("ex_iss",   0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("ex_c1",    0, 1, 1, 2, 0, 0, 1, 2, 1, 0, 0, 6'd7, 0, 1, 0, 0);
    cyc("ex_c2",    0, 1, 1, 2, 0, 0, 1, 2, 1, 0, 0, 6'd7, 0, 1, 2, 0);
    cyc("ex_c3",    0, 1, 1, 2, 0, 0, 1, 2, 1, 0, 0, 6'd7, 0, 1, 2, 0);
    cyc("ex_raw",   0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd3, 1, 0, 2, 0);
    cyc("ex_wb",    0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 2, 6'd0, 0, 0, 1, 0);
    cyc("ex_noinc", 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    // Simultaneous issue+retire on r5, then retire r5 while ID reads it
    cyc("sim_iss",  0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("sim_both", 0, 1, 0, 0, 0, 0, 1, 5, 0, 1, 5, 6'd0, 0, 0, 0, 0);
    cyc("sim_rdwb", 0, 1, 0, 0, 1, 5, 0, 0, 0, 1, 5, 6'd0, 0, 0, 0, 0);
    cyc("sim_rd",   0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    // Underflow on r7 sets a sticky error that only reset clears
    nxt_chkp = 1'b1; nxt_ps = 16'd6; nxt_pr = 16'd3;
    cyc("err_ret",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 6'd0, 0, 0, 0, 0);
    cyc("err_set",  0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1);
    cyc("err_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1);
    cyc("err_rst",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 1);
    cyc("err_clr",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    // Saturation of r9 at 3, RAW via second operand, id_valid gating
    cyc("sat_1",    0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("sat_2",    0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("sat_3",    0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("sat_4",    0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    cyc("sat_raw2", 0, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 6'd3, 1, 0, 0, 1);
    cyc("sat_nov",  0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 6'd0, 0, 0, 1, 1);
    cyc("sat_rst",  1, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, 0, 0, 1);
    cyc("sat_clr",  0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
